// File: rtl/audio_pll_lock_sequencer.sv
// audio_pll_lock_sequencer: PLL reset sequencing, lock qualification and audio-domain reset release.
// Optional AUDIO_PLL_AUTO_RELOCK_EN: re-reset the PLL when WAIT_LOCK exceeds LOCK_TIMEOUT_CYCLES.
module audio_pll_lock_sequencer #(
  parameter int SYNC_STAGES         = 2,
  parameter int RESET_HOLD_CYCLES   = 16,
  parameter int LOCK_STABLE_CYCLES  = 1024,
  parameter int LOCK_TIMEOUT_CYCLES = 65536,
  parameter int LOSS_CNT_W          = 8
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  pll_locked,
  input  logic                  relock_req,
  input  logic                  clear_lost,
  output logic                  pll_rst,
  output logic                  audio_reset_n,
  output logic                  ready,
  output logic                  lock_lost,
  output logic [LOSS_CNT_W-1:0] loss_count
);
  localparam int M1   = RESET_HOLD_CYCLES > LOCK_STABLE_CYCLES ? RESET_HOLD_CYCLES : LOCK_STABLE_CYCLES;
  localparam int MAXP = M1 > LOCK_TIMEOUT_CYCLES ? M1 : LOCK_TIMEOUT_CYCLES;
  localparam int CW   = $clog2(MAXP) + 1;

  typedef enum logic [1:0] {PLL_RST, WAIT_LOCK, STABLE, RUN} state_t;

  state_t                 state, state_nxt;
  logic [CW-1:0]          cnt, cnt_nxt;
  logic [SYNC_STAGES-1:0] sync;
  logic                   lk, drop, hold;

  assign lk = sync[SYNC_STAGES-1];

`ifdef AUDIO_PLL_AUTO_RELOCK_EN
  assign hold = (state == RUN);
`else
  assign hold = (state == WAIT_LOCK) || (state == RUN);
`endif

  // Synchronise the asynchronous PLL lock flag into clk.
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) sync <= '0;
    else sync <= {sync[SYNC_STAGES-2:0], pll_locked};

  // Next-state, shared counter and RUN lock-drop detection.
  always_comb begin
    state_nxt = state;
    drop      = 1'b0;
    case (state)
      PLL_RST:   if (cnt == CW'(RESET_HOLD_CYCLES - 1)) state_nxt = WAIT_LOCK;
      WAIT_LOCK: if (lk) state_nxt = STABLE;
`ifdef AUDIO_PLL_AUTO_RELOCK_EN
                 else if (cnt == CW'(LOCK_TIMEOUT_CYCLES - 1)) state_nxt = PLL_RST;
`endif
      STABLE:    if (!lk) state_nxt = WAIT_LOCK;
                 else if (cnt == CW'(LOCK_STABLE_CYCLES)) state_nxt = RUN;
      RUN:       if (!lk) begin
                   state_nxt = WAIT_LOCK;
                   drop      = 1'b1;
                 end
      default:   state_nxt = PLL_RST;
    endcase
    if (relock_req && state != PLL_RST) begin
      state_nxt = PLL_RST;
      drop      = 1'b0;
    end
    cnt_nxt = (state_nxt != state) ? ((state_nxt == STABLE) ? CW'(1) : '0)
            : hold ? cnt : cnt + CW'(1);
  end

  // State, counter and outputs decoded from the next state.
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state         <= PLL_RST;
      cnt           <= '0;
      pll_rst       <= 1'b1;
      audio_reset_n <= 1'b0;
      ready         <= 1'b0;
    end else begin
      state         <= state_nxt;
      cnt           <= cnt_nxt;
      pll_rst       <= state_nxt == PLL_RST;
      audio_reset_n <= state_nxt == RUN;
      ready         <= state_nxt == RUN;
    end

  // Sticky loss flag and saturating loss counter; a drop beats a same-cycle clear.
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      lock_lost  <= 1'b0;
      loss_count <= '0;
    end else if (drop) begin
      lock_lost  <= 1'b1;
      loss_count <= clear_lost ? LOSS_CNT_W'(1) : (&loss_count ? loss_count : loss_count + LOSS_CNT_W'(1));
    end else if (clear_lost) begin
      lock_lost  <= 1'b0;
      loss_count <= '0;
    end
endmodule

// File: tb/tb_audio_pll_lock_sequencer.sv
// tb_audio_pll_lock_sequencer: directed self-checking bench for audio_pll_lock_sequencer.
module tb_audio_pll_lock_sequencer;
`ifdef AUDIO_PLL_AUTO_RELOCK_EN
  localparam bit AUTO = 1'b1;
`else
  localparam bit AUTO = 1'b0;
`endif

  logic       clk = 1'b0, reset_n = 1'b0, pll_locked = 1'b0, relock_req = 1'b0, clear_lost = 1'b0;
  logic       pll_rst, audio_reset_n, ready, lock_lost;
  logic [1:0] loss_count;
  int         checks = 0, errors = 0;

  audio_pll_lock_sequencer #(
    .SYNC_STAGES(2), .RESET_HOLD_CYCLES(4), .LOCK_STABLE_CYCLES(8),
    .LOCK_TIMEOUT_CYCLES(32), .LOSS_CNT_W(2)
  ) dut (
    .clk(clk), .reset_n(reset_n), .pll_locked(pll_locked), .relock_req(relock_req),
    .clear_lost(clear_lost), .pll_rst(pll_rst), .audio_reset_n(audio_reset_n),
    .ready(ready), .lock_lost(lock_lost), .loss_count(loss_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // pll_locked was just raised; the next edge is the first to sample it.
  task automatic release_after(input string tag);
    tick(10);
    check({tag, " held"}, audio_reset_n, 0);
    tick(1);
    check({tag, " arn"}, audio_reset_n, 1);
    check({tag, " ready"}, ready, 1);
  endtask

  initial begin
    tick(2);
    check("rst pll_rst", pll_rst, 1);
    check("rst arn", audio_reset_n, 0);
    check("rst ready", ready, 0);
    check("rst lock_lost", lock_lost, 0);
    check("rst loss", loss_count, 0);
    reset_n = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      tick();
      check("t1 pll_rst", pll_rst, k < 4);
    end
    tick(5);
    pll_locked = 1'b1;
    release_after("t1");
    for (int i = 1; i <= 4; i++) begin
      pll_locked = 1'b0;
      tick(2);
      check("t3 arn early", audio_reset_n, 1);
      tick();
      check("t3 arn drop", audio_reset_n, 0);
      check("t3 lock_lost", lock_lost, 1);
      check("t3 loss", loss_count, i < 3 ? i : 3);
      pll_locked = 1'b1;
      release_after("t3");
    end
    relock_req = 1'b1;
    tick();
    relock_req = 1'b0;
    pll_locked = 1'b0;
    check("t5 ready", ready, 0);
    check("t5 pll_rst rise", pll_rst, 1);
    tick(3);
    check("t5 pll_rst hold", pll_rst, 1);
    tick();
    check("t5 pll_rst fall", pll_rst, 0);
    check("t5 loss", loss_count, 3);
    check("t5 lock_lost", lock_lost, 1);
    pll_locked = 1'b1;
    tick(7);
    check("t2 arn pre", audio_reset_n, 0);
    pll_locked = 1'b0;
    tick();
    pll_locked = 1'b1;
    release_after("t2");
    pll_locked = 1'b0;
    tick(2);
    clear_lost = 1'b1;
    tick();
    clear_lost = 1'b0;
    check("t4 lock_lost", lock_lost, 1);
    check("t4 loss", loss_count, 1);
    clear_lost = 1'b1;
    tick();
    clear_lost = 1'b0;
    check("t4 clr lock_lost", lock_lost, 0);
    check("t4 clr loss", loss_count, 0);
    pll_locked = 1'b1;
    release_after("t4");
    pll_locked = 1'b0;
    tick(3);
    check("t6 loss", loss_count, 1);
    pll_locked = 1'b1;
    release_after("t6");
    #2;
    reset_n = 1'b0;
    #1;
    check("t6 async pll_rst", pll_rst, 1);
    check("t6 async arn", audio_reset_n, 0);
    check("t6 async ready", ready, 0);
    check("t6 async lock_lost", lock_lost, 0);
    check("t6 async loss", loss_count, 0);
    pll_locked = 1'b0;
    tick();
    reset_n = 1'b1;
    for (int k = 1; k <= 45; k++) begin
      tick();
      check("t6 timeout pll_rst", pll_rst, (k < 4) || (AUTO && (k % 36) < 4));
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
